// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared types, keypoint field helpers and octant bin codes
package sift_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_REQ,
        KEY_WAIT,
        PIX,
        PIX_WAIT,
        CALC,
        WRITE,
        FINISH
    } ori_state_t;

    localparam logic [2:0] BIN_0 = 3'd0;
    localparam logic [2:0] BIN_1 = 3'd1;
    localparam logic [2:0] BIN_2 = 3'd2;
    localparam logic [2:0] BIN_3 = 3'd3;
    localparam logic [2:0] BIN_4 = 3'd4;
    localparam logic [2:0] BIN_5 = 3'd5;
    localparam logic [2:0] BIN_6 = 3'd6;
    localparam logic [2:0] BIN_7 = 3'd7;

    // Keypoint word is {layer, x[cw-1:0], y[cw-1:0]}; cw is the coordinate width.
    function automatic logic [15:0] key_x(input logic [31:0] key, input int cw);
        logic [31:0] mask;
        mask = (32'd1 << cw) - 32'd1;
        return 16'((key >> cw) & mask);
    endfunction

    function automatic logic [15:0] key_y(input logic [31:0] key, input int cw);
        logic [31:0] mask;
        mask = (32'd1 << cw) - 32'd1;
        return 16'(key & mask);
    endfunction

    function automatic logic key_layer(input logic [31:0] key, input int cw);
        logic [31:0] sh;
        sh = key >> (2 * cw);
        return sh[0];
    endfunction

endpackage

// File: rtl/gradient_octant.sv
// rtl/gradient_octant.sv - central-difference gradient to octant bin and L1 magnitude
module gradient_octant
    import sift_pkg::*;
#(
    parameter int IMG_BIT_DEPTH = 8
) (
    input  logic [IMG_BIT_DEPTH-1:0] l,
    input  logic [IMG_BIT_DEPTH-1:0] r,
    input  logic [IMG_BIT_DEPTH-1:0] u,
    input  logic [IMG_BIT_DEPTH-1:0] d,
    output logic [2:0]               bin,
    output logic [IMG_BIT_DEPTH:0]   mag
);
    localparam int W = IMG_BIT_DEPTH;

    logic signed [W:0] dx;
    logic signed [W:0] dy;
    logic [W:0]        ndx;
    logic [W:0]        ndy;
    logic [W:0]        adx;
    logic [W:0]        ady;
    logic              sx;
    logic              sy;
    logic              st;

    assign dx  = $signed({1'b0, r}) - $signed({1'b0, l});
    assign dy  = $signed({1'b0, d}) - $signed({1'b0, u});
    assign ndx = -dx;
    assign ndy = -dy;
    assign sx  = dx[W];
    assign sy  = dy[W];
    assign adx = sx ? ndx : dx;
    assign ady = sy ? ndy : dy;
    assign st  = ady > adx;
    // Each magnitude is at most 2^W-1, so the sum fits in W+1 bits.
    assign mag = adx + ady;

    always_comb begin
        bin = BIN_0;
        case ({sy, sx, st})
            3'b000:  bin = BIN_0;
            3'b001:  bin = BIN_1;
            3'b011:  bin = BIN_2;
            3'b010:  bin = BIN_3;
            3'b110:  bin = BIN_4;
            3'b111:  bin = BIN_5;
            3'b101:  bin = BIN_6;
            3'b100:  bin = BIN_7;
            default: bin = BIN_0;
        endcase
    end

endmodule

// File: rtl/keypoint_orientation.sv
// rtl/keypoint_orientation.sv - per-keypoint gradient octant and magnitude writer
module keypoint_orientation
    import sift_pkg::*;
#(
    parameter int  DIMENSION     = 64,
    parameter int  IMG_BIT_DEPTH = 8,
    localparam int AW            = $clog2(DIMENSION * DIMENSION),
    localparam int CW            = $clog2(DIMENSION),
    localparam int KW            = 2 * CW + 1,
    localparam int OW            = KW + 3 + IMG_BIT_DEPTH + 1
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     start,
    input  logic [AW-1:0]            key_count,
    output logic [AW-1:0]            key_read_addr,
    input  logic [KW-1:0]            key_data,
    output logic [AW-1:0]            img_read_addr,
    input  logic [IMG_BIT_DEPTH-1:0] img_data,
    output logic [AW-1:0]            ori_write_addr,
    output logic                     ori_wea,
    output logic [OW-1:0]            ori_out,
    output logic                     busy,
    output logic                     done
);
    localparam logic [CW-1:0] CMAX = CW'(DIMENSION - 1);

    ori_state_t               state;
    logic [3:0]               step;
    logic [AW-1:0]            index;
    logic [AW-1:0]            count;
    logic [KW-1:0]            key_reg;
    logic [IMG_BIT_DEPTH-1:0] pl, pr, pu, pd;

    logic [KW-1:0]            src_key;
    logic [CW-1:0]            kx, ky, xm, xp, ym, yp;
    logic [AW-1:0]            addr_l, addr_r, addr_u, addr_d;
    logic [2:0]               g_bin;
    logic [IMG_BIT_DEPTH:0]   g_mag;

    // The left-neighbour address goes out on the same edge that captures the keypoint.
    assign src_key = (state == KEY_WAIT) ? key_data : key_reg;
    assign kx      = CW'(key_x(32'(src_key), CW));
    assign ky      = CW'(key_y(32'(src_key), CW));
    assign xm      = (kx == '0)   ? kx : kx - CW'(1);
    assign xp      = (kx == CMAX) ? kx : kx + CW'(1);
    assign ym      = (ky == '0)   ? ky : ky - CW'(1);
    assign yp      = (ky == CMAX) ? ky : ky + CW'(1);
    assign addr_l  = {ky, xm};
    assign addr_r  = {ky, xp};
    assign addr_u  = {ym, kx};
    assign addr_d  = {yp, kx};

    gradient_octant #(
        .IMG_BIT_DEPTH(IMG_BIT_DEPTH)
    ) u_grad (
        .l  (pl),
        .r  (pr),
        .u  (pu),
        .d  (pd),
        .bin(g_bin),
        .mag(g_mag)
    );

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            step           <= '0;
            index          <= '0;
            count          <= '0;
            key_reg        <= '0;
            pl             <= '0;
            pr             <= '0;
            pu             <= '0;
            pd             <= '0;
            key_read_addr  <= '0;
            img_read_addr  <= '0;
            ori_write_addr <= '0;
            ori_wea        <= 1'b0;
            ori_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ori_wea <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count          <= key_count;
                        index          <= '0;
                        ori_write_addr <= '0;
                        step           <= '0;
                        busy           <= 1'b1;
                        if (key_count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state         <= KEY_REQ;
                            key_read_addr <= '0;
                        end
                    end
                end
                KEY_REQ: begin
                    step  <= step + 4'd1;
                    state <= KEY_WAIT;
                end
                KEY_WAIT: begin
                    step <= step + 4'd1;
                    if (step == 4'd2) begin
                        key_reg       <= key_data;
                        img_read_addr <= addr_l;
                        state         <= PIX;
                    end
                end
                PIX: begin
                    step <= step + 4'd1;
                    case (step)
                        4'd3: img_read_addr <= addr_r;
                        4'd4: img_read_addr <= addr_u;
                        4'd5: begin
                            img_read_addr <= addr_d;
                            pl            <= img_data;
                        end
                        default: begin
                            pr    <= img_data;
                            state <= PIX_WAIT;
                        end
                    endcase
                end
                PIX_WAIT: begin
                    step <= step + 4'd1;
                    if (step == 4'd7) begin
                        pu <= img_data;
                    end else begin
                        pd    <= img_data;
                        state <= CALC;
                    end
                end
                CALC: begin
                    ori_out <= {key_reg, g_bin, g_mag};
                    ori_wea <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    ori_write_addr <= ori_write_addr + AW'(1);
                    index          <= index + AW'(1);
                    if (index + AW'(1) == count) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state         <= KEY_REQ;
                        key_read_addr <= index + AW'(1);
                        step          <= '0;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypoint_orientation.sv
// tb/tb_keypoint_orientation.sv - directed table-driven bench for keypoint_orientation
module tb_keypoint_orientation;
    localparam int DIMENSION = 64;
    localparam int IMG_BIT_DEPTH = 8;
    localparam int AW = 12;
    localparam int KW = 13;
    localparam int OW = 25;

    logic          clk = 1'b0;
    logic          rst_in = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] key_count = '0;
    logic [AW-1:0] key_read_addr;
    logic [KW-1:0] key_data = '0;
    logic [AW-1:0] img_read_addr;
    logic [7:0]    img_data = '0;
    logic [AW-1:0] ori_write_addr;
    logic          ori_wea;
    logic [OW-1:0] ori_out;
    logic          busy;
    logic          done;

    keypoint_orientation #(.DIMENSION(DIMENSION), .IMG_BIT_DEPTH(IMG_BIT_DEPTH)) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .key_count(key_count),
        .key_read_addr(key_read_addr), .key_data(key_data),
        .img_read_addr(img_read_addr), .img_data(img_data),
        .ori_write_addr(ori_write_addr), .ori_wea(ori_wea), .ori_out(ori_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = -100;
    int base = 0, ga = 0, gb = 0, special = 0;

    logic [KW-1:0] key_mem [0:15];
    logic [AW-1:0] ka1 = '0, ia1 = '0;
    logic [AW-1:0] img_hist [0:15];
    logic [AW-1:0] wr_addr [$];
    logic [OW-1:0] wr_data [$];
    int            wr_cyc [$];

    function automatic logic [7:0] pix_at(input logic [AW-1:0] addr);
        int x, y;
        x = int'(addr[5:0]);
        y = int'(addr[11:6]);
        if (special != 0) return (x == 9 || y == 11) ? 8'd255 : 8'd0;
        return 8'(base + ga * x + gb * y);
    endfunction

    function automatic logic [KW-1:0] mk_key(input int x, input int y, input int lay);
        return {1'(lay), 6'(x), 6'(y)};
    endfunction

    function automatic logic [OW-1:0] mk_word(input logic [KW-1:0] k, input int bin, input int mag);
        return {k, 3'(bin), 9'(mag)};
    endfunction

    always @(posedge clk) begin
        ka1      <= key_read_addr;
        key_data <= key_mem[ka1[3:0]];
        ia1      <= img_read_addr;
        img_data <= pix_at(ia1);
        cyc      <= cyc + 1;
    end

    always @(negedge clk) begin
        if (ori_wea) begin
            wr_addr.push_back(ori_write_addr);
            wr_data.push_back(ori_out);
            wr_cyc.push_back(cyc);
        end
        if (cyc - start_cyc - 1 >= 0 && cyc - start_cyc - 1 < 16)
            img_hist[cyc - start_cyc - 1] = img_read_addr;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic pulse_start(input logic [AW-1:0] cnt);
        @(posedge clk); #1;
        start = 1'b1;
        key_count = cnt;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget && dcyc < 0; i++) begin
            @(negedge clk);
            if (done) dcyc = cyc;
        end
    endtask

    typedef struct {
        int x, y, lay, base, a, b, sp, bin, mag;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int d;
        logic [KW-1:0] k;

        vecs[0]  = '{10, 10, 0,   0,  4,  1, 0, 0, 10};
        vecs[1]  = '{10, 10, 0, 200,  0, -3, 0, 6, 6};
        vecs[2]  = '{20, 30, 1, 100,  1,  3, 0, 1, 8};
        vecs[3]  = '{10, 10, 0, 100, -1,  3, 0, 2, 8};
        vecs[4]  = '{10, 10, 0, 100, -3,  1, 0, 3, 8};
        vecs[5]  = '{ 5, 40, 1, 200, -4, -1, 0, 4, 10};
        vecs[6]  = '{10, 10, 0, 200, -1, -4, 0, 5, 10};
        vecs[7]  = '{10, 10, 0, 100,  2, -1, 0, 7, 6};
        vecs[8]  = '{10, 10, 0,  77,  0,  0, 0, 0, 0};
        vecs[9]  = '{10, 10, 0,  50,  2,  2, 0, 0, 8};
        vecs[10] = '{10, 10, 0,   0,  0,  0, 1, 3, 510};
        for (int i = 0; i < 16; i++) begin
            key_mem[i] = '0;
            img_hist[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, ori_wea, ori_out, ori_write_addr, key_read_addr, img_read_addr}), 64'd0);
        rst_in = 1'b1;

        for (int i = 0; i < 11; i++) begin
            base = vecs[i].base; ga = vecs[i].a; gb = vecs[i].b; special = vecs[i].sp;
            k = mk_key(vecs[i].x, vecs[i].y, vecs[i].lay);
            key_mem[0] = k;
            clear_log();
            pulse_start(1);
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            wait_done(40, d);
            check($sformatf("vec%0d_done_lat", i), 64'(d - start_cyc), 64'd12);
            check($sformatf("vec%0d_nwrites", i), 64'(wr_addr.size()), 64'd1);
            if (wr_addr.size() > 0) begin
                check($sformatf("vec%0d_addr", i), 64'(wr_addr[0]), 64'd0);
                check($sformatf("vec%0d_word", i), 64'(wr_data[0]), 64'(mk_word(k, vecs[i].bin, vecs[i].mag)));
            end
        end

        base = 0; ga = 4; gb = 1; special = 0;
        key_mem[0] = mk_key(0, 0, 0);
        clear_log();
        pulse_start(1);
        wait_done(40, d);
        check("c00_addr_l", 64'(img_hist[3]), 64'd0);
        check("c00_addr_r", 64'(img_hist[4]), 64'd1);
        check("c00_addr_u", 64'(img_hist[5]), 64'd0);
        check("c00_addr_d", 64'(img_hist[6]), 64'd64);
        if (wr_data.size() > 0) check("c00_word", 64'(wr_data[0]), 64'(mk_word(key_mem[0], 0, 5)));
        else check("c00_nwrites", 64'(wr_data.size()), 64'd1);

        key_mem[0] = mk_key(63, 63, 0);
        clear_log();
        pulse_start(1);
        wait_done(40, d);
        check("c63_addr_l", 64'(img_hist[3]), 64'd4094);
        check("c63_addr_r", 64'(img_hist[4]), 64'd4095);
        check("c63_addr_u", 64'(img_hist[5]), 64'd4031);
        check("c63_addr_d", 64'(img_hist[6]), 64'd4095);
        if (wr_data.size() > 0) check("c63_word", 64'(wr_data[0]), 64'(mk_word(key_mem[0], 0, 5)));
        else check("c63_nwrites", 64'(wr_data.size()), 64'd1);

        key_mem[0] = mk_key(10, 10, 0);
        key_mem[1] = mk_key(20, 5, 1);
        key_mem[2] = mk_key(30, 40, 0);
        clear_log();
        pulse_start(3);
        check("k3_key_addr0", 64'(key_read_addr), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        key_count = 12'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(60, d);
        check("k3_done_lat", 64'(d - start_cyc - 1), 64'd33);
        check("k3_nwrites", 64'(wr_addr.size()), 64'd3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            check($sformatf("k3_addr%0d", i), 64'(wr_addr[i]), 64'(i));
            check($sformatf("k3_cyc%0d", i), 64'(wr_cyc[i] - start_cyc - 1), 64'(10 + 11 * i));
            check($sformatf("k3_word%0d", i), 64'(wr_data[i]), 64'(mk_word(key_mem[i], 0, 10)));
        end
        @(negedge clk);
        check("k3_busy_after", 64'(busy), 64'd0);

        clear_log();
        pulse_start(0);
        wait_done(10, d);
        check("k0_done_lat", 64'(d - start_cyc), 64'd1);
        @(negedge clk);
        check("k0_busy_after", 64'({busy, done}), 64'd0);
        repeat (5) @(posedge clk);
        check("k0_nwrites", 64'(wr_addr.size()), 64'd0);

        clear_log();
        pulse_start(3);
        repeat (15) @(posedge clk);
        #1;
        check("rst_pre_waddr", 64'(ori_write_addr), 64'd1);
        rst_in = 1'b0;
        #1;
        check("rst_outputs", 64'({busy, done, ori_wea, ori_out, ori_write_addr, key_read_addr, img_read_addr}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rst_nwrites", 64'(wr_addr.size()), 64'd1);
        clear_log();
        pulse_start(3);
        wait_done(60, d);
        check("rst_restart_lat", 64'(d - start_cyc - 1), 64'd33);
        check("rst_restart_n", 64'(wr_addr.size()), 64'd3);
        if (wr_addr.size() > 0) check("rst_restart_addr0", 64'(wr_addr[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/keypoint_orientation.md
# keypoint_orientation

Downstream of the octave-1 keypoint finder. Once keypoint finding completes, this block walks the keypoint BRAM entry by entry and reads the four axis neighbours of each keypoint from the octave-1 Gaussian level-2 image BRAM. For each keypoint it computes a central-difference gradient, quantizes the gradient direction into one of 8 octant bins, and writes `{keypoint, bin, magnitude}` into an orientation BRAM consumed by the descriptor stage.

## Interface
Parameters:
- `DIMENSION`, 64: image side length in pixels; square image, power of two.
- `IMG_BIT_DEPTH`, 8: pixel width, unsigned.

Derived widths:
- AW = $clog2(DIMENSION*DIMENSION).
- CW = $clog2(DIMENSION).
- KW = 2*CW+1.
- OW = KW+3+IMG_BIT_DEPTH+1.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_in` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse, driven from `keypoints_done`.
- `key_count` in AW: number of valid keypoint entries; sampled on `start`.
- `key_read_addr` out AW: keypoint BRAM read address.
- `key_data` in KW: keypoint entry, 2-cycle read latency. Bit [KW-1] is the DoG layer select; [2CW-1:CW] is x; [CW-1:0] is y.
- `img_read_addr` out AW: Gaussian image read address, equal to y*DIMENSION+x; 2-cycle latency.
- `img_data` in IMG_BIT_DEPTH: pixel value.
- `ori_write_addr` out AW: orientation BRAM write address.
- `ori_wea` out 1: orientation BRAM write enable.
- `ori_out` out OW: the word `{key_data, bin[2:0], mag[IMG_BIT_DEPTH:0]}`.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse when all keypoints have been processed.

## Operation
- States are IDLE, KEY_REQ, KEY_WAIT, PIX, PIX_WAIT, CALC, WRITE, FINISH.
- IDLE:
  - On `start`, latch `key_count` and clear the keypoint index and `ori_write_addr`.
  - If the latched count is 0, go to FINISH; otherwise go to KEY_REQ.
  - `start` received outside IDLE is ignored.
- KEY_REQ: drive `key_read_addr` = index. Hold KEY_WAIT for 2 cycles, then capture `key_data`.
- PIX: issue 4 image reads on consecutive cycles, in this order:
  - L = (x-1, y)
  - R = (x+1, y)
  - U = (x, y-1)
  - D = (x, y+1)
- Border coordinates clamp to the range [0, DIMENSION-1], i.e. pixels are replicated at the edges.
- PIX_WAIT: capture each pixel exactly 2 cycles after its address was issued.
- CALC:
  - dx = R−L and dy = D−U, each signed, IMG_BIT_DEPTH+1 bits.
  - mag = |dx|+|dy|, unsigned, IMG_BIT_DEPTH+1 bits, no overflow (max 510).
  - Let sx = dx<0, sy = dy<0, st = |dy|>|dx|. The bin is:
    - bin 0: sy=0, sx=0, st=0
    - bin 1: sy=0, sx=0, st=1
    - bin 2: sy=0, sx=1, st=1
    - bin 3: sy=0, sx=1, st=0
    - bin 4: sy=1, sx=1, st=0
    - bin 5: sy=1, sx=1, st=1
    - bin 6: sy=1, sx=0, st=1
    - bin 7: sy=1, sx=0, st=0
  - dx=dy=0 gives bin 0, mag 0.
- WRITE:
  - Assert `ori_wea` for one cycle with `ori_out` valid at `ori_write_addr`.
  - On the next edge, increment both `ori_write_addr` and the index.
  - If index+1 equals the count, go to FINISH; otherwise go to KEY_REQ.
- FINISH: pulse `done` for one cycle, drop `busy`, return to IDLE.
- The layer bit passes through untouched. Both layers use the same image.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE.
- Reset asserted mid-run aborts immediately with no partial write. The next `start` reprocesses from entry 0.
- Per-keypoint cycle schedule, relative to KEY_REQ at cycle 0:
  - `key_read_addr` valid at 0; data captured at 2.
  - Image addresses at cycles 3, 4, 5, 6; data captured at 5, 6, 7, 8.
  - CALC at 9.
  - `ori_wea` at 10.
  - Next KEY_REQ at 11.
- Throughput is fixed at 11 cycles per keypoint.
- `done` rises the cycle after the last WRITE.
- With count=0, `done` rises 1 cycle after `start`.
- Total run time from `start` to `done` is 11·N+1 cycles.
- `img_read_addr` and `key_read_addr` hold their last values when not in use. Consumers must treat them as don't-care outside PIX and KEY_REQ.
- `busy` lets the top level mux `img_read_addr` onto the shared image port.

## Structure
- Package `sift_pkg` holds:
  - The state enum `ori_state_t`.
  - The keypoint field slicing functions (`key_x`, `key_y`, `key_layer`).
  - The bin constants.
- Sub-module `gradient_octant`: combinational, takes L, R, U, D and produces bin and mag. It is instantiated once and is unit-testable in isolation.

## Test plan
- Single keypoint x=10, y=10 (layer 0) on a ramp image with pixel = 4x + y:
  - Expect dx=8, dy=2, bin 0, mag 10.
  - Expect one write at addr 0, `done` at cycle 12 after `start`.
- Keypoint (10,10) with pixel = 200 − 3y:
  - Expect dy=−6, dx=0, st=1, sx=0, sy=1 → bin 6, mag 6.
- Corner keypoint (0,0):
  - Expect image reads at addresses 0, 1, 0, 64; x and y clamp, no out-of-range address.
- Three keypoints; `start` re-pulsed at cycle 5:
  - Writes at addrs 0, 1, 2 on cycles 10, 21, 32.
  - Second `start` ignored; `done` at cycle 33.
- key_count=0: no `ori_wea`; `done` pulses 1 cycle after `start`; `busy` never held past that cycle.
- `rst_in` asserted low at cycle 15 of a 3-keypoint run:
  - All outputs 0 immediately; no further writes.
  - A fresh `start` writes from addr 0 again.
